// File: rtl/writeback_unit.sv
// Single-entry writeback stage: selects the result, holds it until the register
// file accepts it, and mirrors it on the forwarding bus. WB_PERF_CNT_EN adds retire/stall counters.
module writeback_lane #(
  parameter int LANE_W = 32
) (
  input  logic [1:0]        src,
  input  logic [LANE_W-1:0] alu,
  input  logic [LANE_W-1:0] ld,
  input  logic [LANE_W-1:0] link,
  input  logic [LANE_W-1:0] imm,
  output logic [LANE_W-1:0] sel
);
  always_comb begin
    sel = alu;
    case (src)
      2'b00: sel = alu;
      2'b01: sel = ld;
      2'b10: sel = link;
      2'b11: sel = imm;
      default: sel = alu;
    endcase
  end
endmodule

module writeback_unit #(
  parameter int DATA_W = 128,
  parameter int LANES  = 4,
  parameter int PC_W   = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [1:0]        result_src,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_result,
  input  logic [PC_W-1:0]   pc_plus_4,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              reg_write,
  input  logic [LANES-1:0]  lane_mask,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [LANES-1:0]  rf_wmask,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int LANE_W = DATA_W / LANES;

  if (DATA_W % LANES != 0) begin : g_bad_cfg
    $error("writeback_unit: DATA_W must be divisible by LANES");
  end

  logic                          valid_q, we_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [LANES-1:0][LANE_W-1:0]  data_q;
  logic [LANES-1:0]              mask_q;

  logic [DATA_W-1:0]             link_ext;
  logic [LANES-1:0][LANE_W-1:0]  sel_data;
  logic [LANES-1:0]              eff_mask;
  logic                          acc_we, leave, accept;

  assign link_ext = DATA_W'(pc_plus_4);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    writeback_lane #(.LANE_W(LANE_W)) u_lane (
      .src  (result_src),
      .alu  (alu_result[l*LANE_W +: LANE_W]),
      .ld   (read_result[l*LANE_W +: LANE_W]),
      .link (link_ext[l*LANE_W +: LANE_W]),
      .imm  (imm_ext[l*LANE_W +: LANE_W]),
      .sel  (sel_data[l])
    );
  end

  // Link values only ever carry a scalar, so they land in lane 0 alone.
  assign eff_mask = (result_src == 2'b10) ? LANES'(1) : lane_mask;
  assign acc_we   = reg_write && (|rd_addr) && (|eff_mask);

  assign leave    = valid_q && (!we_q || rf_ready);
  assign in_ready = !valid_q || leave;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      we_q    <= acc_we;
      addr_q  <= rd_addr;
      data_q  <= sel_data;
      mask_q  <= eff_mask;
    end else if (leave) begin
      valid_q <= 1'b0;
    end
  end

  assign rf_we     = valid_q && we_q;
  assign rf_waddr  = addr_q;
  assign rf_wdata  = data_q;
  assign rf_wmask  = mask_q;
  assign fwd_valid = rf_we;
  assign fwd_addr  = addr_q;
  assign fwd_data  = data_q;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (leave) retired_cnt <= retired_cnt + 32'd1;
      if (rf_we && !rf_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Randomized + directed bench for writeback_unit against a queue-based entry model.
module tb_writeback_unit;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, flush, reg_write, rf_ready;
  logic [1:0]   result_src;
  logic [127:0] alu_result, read_result, imm_ext;
  logic [31:0]  pc_plus_4;
  logic [3:0]   rd_addr, lane_mask;
  logic         in_ready, rf_we, fwd_valid;
  logic [3:0]   rf_waddr, rf_wmask, fwd_addr;
  logic [127:0] rf_wdata, fwd_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0]  retired_cnt, stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .result_src(result_src), .alu_result(alu_result), .read_result(read_result),
    .pc_plus_4(pc_plus_4), .imm_ext(imm_ext), .rd_addr(rd_addr), .reg_write(reg_write),
    .lane_mask(lane_mask), .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wmask(rf_wmask), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data)
`ifdef WB_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] data;
    logic [3:0]   mask;
    logic         we;
  } ent_t;

  ent_t        held[$];
  int unsigned m_ret, m_stall;

  function automatic ent_t mk_entry();
    ent_t e;
    case (result_src)
      2'b00: e.data = alu_result;
      2'b01: e.data = read_result;
      2'b10: e.data = 128'(pc_plus_4);
      default: e.data = imm_ext;
    endcase
    e.mask = (result_src == 2'b10) ? 4'b0001 : lane_mask;
    e.addr = rd_addr;
    e.we   = reg_write && rd_addr != 0 && e.mask != 0;
    return e;
  endfunction

  // Advance the model with the currently driven inputs, then cross one rising edge.
  task automatic tick();
    bit busy, lv, st, acc;
    ent_t e;
    busy = held.size() != 0;
    lv   = busy && (!held[0].we || rf_ready);
    st   = busy && held[0].we && !rf_ready;
    acc  = in_valid && (!busy || lv) && !flush;
    e    = mk_entry();
    if (!rst_n) begin
      held.delete(); m_ret = 0; m_stall = 0;
    end else begin
      if (lv) m_ret++;
      if (st) m_stall++;
      if (flush) held.delete();
      else begin
        if (lv) void'(held.pop_front());
        if (acc) held.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; reg_write = 1; rf_ready = 1; result_src = 0;
    alu_result = '0; read_result = '0; imm_ext = '0; pc_plus_4 = '0;
    rd_addr = 0; lane_mask = 4'hF;
  endtask

  task automatic test_reset();
    idle_inputs(); rst_n = 0;
    tick(); tick();
    rst_n = 1; #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retired_cnt !== 0 || stall_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", retired_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_alu();
    in_valid = 1; result_src = 2'b00; rd_addr = 5; lane_mask = 4'hF; rf_ready = 1;
    alu_result = 128'h01234567_89ABCDEF_CAFEF00D_DEADBEEF;
    tick(); in_valid = 0; #1;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_rf_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 4'd5) begin failures++; $display("FAIL alu_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 128'h01234567_89ABCDEF_CAFEF00D_DEADBEEF) begin failures++; $display("FAIL alu_wdata got=%h", rf_wdata); end
    checks++; if (rf_wmask !== 4'hF) begin failures++; $display("FAIL alu_wmask got=%b exp=1111", rf_wmask); end
    checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 4'd5) begin failures++; $display("FAIL alu_fwd got=%b/%0d exp=1/5", fwd_valid, fwd_addr); end
    tick();
  endtask

  task automatic test_pc_link();
    in_valid = 1; result_src = 2'b10; rd_addr = 1; lane_mask = 4'hF;
    pc_plus_4 = 32'h0000_1004; alu_result = '1;
    tick(); in_valid = 0; #1;
    checks++; if (rf_wdata !== 128'h1004) begin failures++; $display("FAIL link_wdata got=%h exp=1004", rf_wdata); end
    checks++; if (rf_wmask !== 4'b0001) begin failures++; $display("FAIL link_wmask got=%b exp=0001", rf_wmask); end
    tick();
  endtask

  task automatic test_rd_zero();
    int unsigned r0;
    r0 = m_ret;
    in_valid = 1; result_src = 2'b00; rd_addr = 0; reg_write = 1; rf_ready = 0;
    tick(); in_valid = 0; #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rd0_rf_we got=%b exp=0", rf_we); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rd0_in_ready got=%b exp=1", in_ready); end
    tick(); #1;
    checks++; if (in_ready !== 1'b1 || rf_we !== 1'b0) begin failures++; $display("FAIL rd0_retire got=%b/%b exp=1/0", in_ready, rf_we); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retired_cnt !== r0 + 1) begin failures++; $display("FAIL rd0_retired got=%0d exp=%0d", retired_cnt, r0 + 1); end
`endif
    rf_ready = 1;
  endtask

  task automatic test_stall();
    int unsigned s0;
    in_valid = 1; result_src = 2'b11; rd_addr = 7; imm_ext = 128'hA5; rf_ready = 1;
    tick();
    s0 = m_stall;
    rd_addr = 9; imm_ext = 128'h5A; rf_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd7 || rf_wdata !== 128'hA5) begin failures++; $display("FAIL stall_hold c%0d got=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready c%0d got=%b exp=0", i, in_ready); end
      tick();
    end
`ifdef WB_PERF_CNT_EN
    checks++; if (stall_cnt !== s0 + 3) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, s0 + 3); end
`endif
    rf_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", in_ready); end
    tick(); in_valid = 0; #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 4'd9 || rf_wdata !== 128'h5A) begin failures++; $display("FAIL stall_next got=%b/%0d/%h exp=1/9/5a", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_flush_stall();
    int unsigned r0;
    in_valid = 1; result_src = 2'b01; rd_addr = 3; read_result = 128'h77; rf_ready = 0;
    tick(); in_valid = 0;
    r0 = m_ret; #1;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL flush_pre got=%b exp=1", rf_we); end
    flush = 1; in_valid = 1;
    tick(); flush = 0; in_valid = 0; #1;
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL flush_rf_we got=%b/%b exp=0/0", rf_we, fwd_valid); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retired_cnt !== r0) begin failures++; $display("FAIL flush_retired got=%0d exp=%0d", retired_cnt, r0); end
`endif
    rf_ready = 1;
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1; result_src = 2'b00; rd_addr = 12; alu_result = 128'h99; rf_ready = 0;
    tick(); in_valid = 0; tick();
    rst_n = 0; tick(); rst_n = 1; #1;
    checks++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid got=%b/%b exp=0/1", rf_we, in_ready); end
`ifdef WB_PERF_CNT_EN
    checks++; if (retired_cnt !== 0 || stall_cnt !== 0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", retired_cnt, stall_cnt); end
`endif
    rf_ready = 1;
  endtask

  task automatic test_random();
    bit busy;
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      rf_ready    = ($urandom_range(0, 9) < 7);
      reg_write   = ($urandom_range(0, 7) != 0);
      result_src  = 2'($urandom_range(0, 3));
      rd_addr     = 4'($urandom_range(0, 15));
      lane_mask   = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      alu_result  = {$urandom, $urandom, $urandom, $urandom};
      read_result = {$urandom, $urandom, $urandom, $urandom};
      imm_ext     = {$urandom, $urandom, $urandom, $urandom};
      pc_plus_4   = $urandom;
      #1;
      busy = held.size() != 0;
      checks++; if (rf_we !== (busy && held[0].we)) begin failures++; $display("FAIL rnd_rf_we c%0d got=%b", i, rf_we); end
      checks++; if (fwd_valid !== rf_we) begin failures++; $display("FAIL rnd_fwd_valid c%0d got=%b exp=%b", i, fwd_valid, rf_we); end
      checks++; if (in_ready !== (!busy || !held[0].we || rf_ready)) begin failures++; $display("FAIL rnd_in_ready c%0d got=%b", i, in_ready); end
      if (busy && held[0].we) begin
        checks++;
        if (rf_waddr !== held[0].addr || rf_wdata !== held[0].data || rf_wmask !== held[0].mask ||
            fwd_addr !== held[0].addr || fwd_data !== held[0].data) begin
          failures++;
          $display("FAIL rnd_entry c%0d got=%0d/%h/%b exp=%0d/%h/%b", i, rf_waddr, rf_wdata, rf_wmask,
                   held[0].addr, held[0].data, held[0].mask);
        end
      end
`ifdef WB_PERF_CNT_EN
      checks++; if (retired_cnt !== m_ret || stall_cnt !== m_stall) begin failures++; $display("FAIL rnd_cnt c%0d got=%0d/%0d exp=%0d/%0d", i, retired_cnt, stall_cnt, m_ret, m_stall); end
`endif
      tick();
    end
  endtask

  initial begin
    m_ret = 0; m_stall = 0;
    test_reset();
    test_alu();
    test_pc_link();
    test_rd_zero();
    test_stall();
    test_flush_stall();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
